// File: rtl/mem_access_unit.sv
// M-stage load/store engine: drives a word-addressed variable-latency bus with byte enables,
// extends load data and reports AdEL/AdES/DBE. Define MEM_UNALIGNED_SPLIT_EN to split word-crossing accesses.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_exc,
    output logic [4:0]        resp_exc_code,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]       EXC_ADEL = 5'd4;
    localparam logic [4:0]       EXC_ADES = 5'd5;
    localparam logic [4:0]       EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size, input logic uns);
        case (size)
            2'd0:    extend = {{24{raw[7] & ~uns}}, raw[7:0]};
            2'd1:    extend = {{16{raw[15] & ~uns}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              we_r, we_s, uns_r, uns_s, split_r, split_s;
    logic [1:0]        size_r, size_s, off_r, off_s;
    logic [3:0]        be_hi_r, be_hi_s;
    logic [31:0]       wdata_hi_r, wdata_hi_s, acc_r, acc_s;
    logic              bus_req_r, bus_req_s, bus_we_r, bus_we_s;
    logic [ADDR_W-1:0] bus_addr_r, bus_addr_s;
    logic [3:0]        bus_be_r, bus_be_s;
    logic [31:0]       bus_wdata_r, bus_wdata_s;
    logic              resp_valid_r, resp_valid_s, resp_exc_r, resp_exc_s;
    logic [4:0]        resp_code_r, resp_code_s;
    logic [31:0]       resp_rdata_r, resp_rdata_s;

    logic [1:0]        dec_size_s;
    logic [7:0]        dec_mask_s;
    logic [63:0]       dec_wdata_s;
    logic              dec_fault_s, dec_split_s;
    logic [31:0]       ld_raw_s;

    // Decode the presented request; only consumed on the accept cycle
    always_comb begin
        dec_size_s  = (req_size == 2'd3) ? 2'd2 : req_size;
        dec_mask_s  = {4'b0000, size_mask(dec_size_s)} << req_addr[1:0];
        dec_wdata_s = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
`ifdef MEM_UNALIGNED_SPLIT_EN
        dec_fault_s = 1'b0;
        dec_split_s = |dec_mask_s[7:4];
`else
        dec_fault_s = ((dec_size_s == 2'd1) && req_addr[0]) ||
                      ((dec_size_s == 2'd2) && (req_addr[1:0] != 2'b00));
        dec_split_s = 1'b0;
`endif
    end

    // Load bytes gathered low-first: beat0 supplies the bytes from the offset up, beat1 the rest
    always_comb begin
        if (state_r == BEAT1) begin
            ld_raw_s = acc_r | (bus_rdata << (6'd32 - {1'b0, off_r, 3'b000}));
        end else begin
            ld_raw_s = bus_rdata >> {off_r, 3'b000};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        we_s         = we_r;
        uns_s        = uns_r;
        split_s      = split_r;
        size_s       = size_r;
        off_s        = off_r;
        be_hi_s      = be_hi_r;
        wdata_hi_s   = wdata_hi_r;
        acc_s        = acc_r;
        bus_req_s    = bus_req_r;
        bus_addr_s   = bus_addr_r;
        bus_we_s     = bus_we_r;
        bus_be_s     = bus_be_r;
        bus_wdata_s  = bus_wdata_r;
        resp_valid_s = 1'b0;
        resp_exc_s   = 1'b0;
        resp_code_s  = 5'd0;
        resp_rdata_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    we_s       = req_we;
                    uns_s      = req_unsigned;
                    size_s     = dec_size_s;
                    off_s      = req_addr[1:0];
                    split_s    = dec_split_s;
                    be_hi_s    = dec_mask_s[7:4];
                    wdata_hi_s = dec_wdata_s[63:32];
                    acc_s      = 32'd0;
                    cnt_s      = '0;
                    if (dec_fault_s) begin
                        state_s      = DONE;
                        resp_valid_s = 1'b1;
                        resp_exc_s   = 1'b1;
                        resp_code_s  = req_we ? EXC_ADES : EXC_ADEL;
                    end else begin
                        state_s     = BEAT0;
                        bus_req_s   = 1'b1;
                        bus_addr_s  = {req_addr[ADDR_W-1:2], 2'b00};
                        bus_we_s    = req_we;
                        bus_be_s    = dec_mask_s[3:0];
                        bus_wdata_s = dec_wdata_s[31:0];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BEAT0, BEAT1: begin
                if (bus_ack) begin
                    cnt_s = '0;
                    if ((state_r == BEAT0) && split_r) begin
                        state_s     = BEAT1;
                        acc_s       = ld_raw_s;
                        bus_addr_s  = bus_addr_r + ADDR_W'(3'd4);
                        bus_be_s    = be_hi_r;
                        bus_wdata_s = wdata_hi_r;
                    end else begin
                        state_s      = DONE;
                        bus_req_s    = 1'b0;
                        bus_we_s     = 1'b0;
                        bus_be_s     = 4'b0000;
                        resp_valid_s = 1'b1;
                        resp_rdata_s = we_r ? 32'd0 : extend(ld_raw_s, size_r, uns_r);
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s      = DONE;
                    bus_req_s    = 1'b0;
                    bus_we_s     = 1'b0;
                    bus_be_s     = 4'b0000;
                    resp_valid_s = 1'b1;
                    resp_exc_s   = 1'b1;
                    resp_code_s  = EXC_DBE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1'b1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            we_r         <= 1'b0;
            uns_r        <= 1'b0;
            split_r      <= 1'b0;
            size_r       <= 2'd0;
            off_r        <= 2'd0;
            be_hi_r      <= 4'b0000;
            wdata_hi_r   <= 32'd0;
            acc_r        <= 32'd0;
            bus_req_r    <= 1'b0;
            bus_addr_r   <= '0;
            bus_we_r     <= 1'b0;
            bus_be_r     <= 4'b0000;
            bus_wdata_r  <= 32'd0;
            resp_valid_r <= 1'b0;
            resp_exc_r   <= 1'b0;
            resp_code_r  <= 5'd0;
            resp_rdata_r <= 32'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            we_r         <= we_s;
            uns_r        <= uns_s;
            split_r      <= split_s;
            size_r       <= size_s;
            off_r        <= off_s;
            be_hi_r      <= be_hi_s;
            wdata_hi_r   <= wdata_hi_s;
            acc_r        <= acc_s;
            bus_req_r    <= bus_req_s;
            bus_addr_r   <= bus_addr_s;
            bus_we_r     <= bus_we_s;
            bus_be_r     <= bus_be_s;
            bus_wdata_r  <= bus_wdata_s;
            resp_valid_r <= resp_valid_s;
            resp_exc_r   <= resp_exc_s;
            resp_code_r  <= resp_code_s;
            resp_rdata_r <= resp_rdata_s;
        end
    end

    assign req_ready     = (state_r == IDLE) && !reset;
    assign stall         = req_valid && !resp_valid_r;
    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = resp_rdata_r;
    assign resp_exc      = resp_exc_r;
    assign resp_exc_code = resp_code_r;
    assign bus_req       = bus_req_r;
    assign bus_addr      = bus_addr_r;
    assign bus_we        = bus_we_r;
    assign bus_be        = bus_be_r;
    assign bus_wdata     = bus_wdata_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a bus responder checks issued beats, a monitor checks responses.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, stall, resp_valid, resp_exc;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_exc_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc), .resp_exc_code(resp_exc_code),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] rdata;
        int          t;
        int          lat;
        int          tag;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    int    checks = 0, errors = 0, cyc = 0, req_cycles = 0, seen = 0;
    logic  ack_now = 1'b0, force_ack = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: checks each beat's command on its first cycle, acks after wait_n cycles
    always @(negedge clk) begin
        if (reset) begin
            beat_q.delete();
            seen    = 0;
            ack_now = 1'b0;
        end else begin
            if (ack_now) begin
                if (beat_q.size() != 0) void'(beat_q.pop_front());
                ack_now = 1'b0;
                seen    = 0;
            end
            if (bus_req) begin
                req_cycles++;
                if (beat_q.size() != 0) begin
                    if (seen == 0) begin
                        chk("bus_addr", bus_addr, beat_q[0].addr);
                        chk("bus_be", 32'(bus_be), 32'(beat_q[0].be));
                        chk("bus_we", 32'(bus_we), 32'(beat_q[0].we));
                        if (beat_q[0].we) chk("bus_wdata", bus_wdata, beat_q[0].wdata);
                    end
                    if (seen == beat_q[0].wait_n) begin
                        ack_now   = 1'b1;
                        bus_rdata = beat_q[0].rdata;
                    end
                    seen++;
                end
            end
        end
        bus_ack = ack_now | force_ack;
    end

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("resp_exc#%0d", e.tag), 32'(resp_exc), 32'(e.exc));
                chk($sformatf("resp_code#%0d", e.tag), 32'(resp_exc_code), 32'(e.code));
                chk($sformatf("resp_rdata#%0d", e.tag), resp_rdata, e.rdata);
                chk($sformatf("latency#%0d", e.tag), 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                             input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wd; b.rdata = rd; b.wait_n = wait_n;
        beat_q.push_back(b);
    endtask

    task automatic issue(input int tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exc, input logic [4:0] code, input logic [31:0] rd, input int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_wait#%0d: req_ready stayed 0 for 20 cycles, expected 1", tag);
            req_valid = 1'b0;
        end else begin
            e.exc = exc; e.code = code; e.rdata = rd; e.t = cyc; e.lat = lat; e.tag = tag;
            exp_q.push_back(e);
            @(negedge clk);
            chk($sformatf("ready_busy#%0d", tag), 32'(req_ready), 32'd0);
            chk($sformatf("stall#%0d", tag), 32'(stall), 32'(lat != 1));
            req_valid = 1'b0;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL resp_wait#%0d: no resp_valid within 50 cycles, expected one", tag);
                exp_q.delete();
            end
        end
    endtask

    initial begin
        int rc;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_exc", 32'(resp_exc), 32'd0);
        chk("rst_resp_code", 32'(resp_exc_code), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);

        push_beat(32'h1000, 4'b1111, 1'b0, 32'd0, 32'hDEADBEEF, 0);
        issue(1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 1'b0, 5'd0, 32'hDEADBEEF, 2);
        push_beat(32'h1000, 4'b1100, 1'b0, 32'd0, 32'h80011234, 0);
        issue(2, 1'b0, 2'd1, 1'b0, 32'h1002, 32'd0, 1'b0, 5'd0, 32'hFFFF8001, 2);
        push_beat(32'h1000, 4'b1100, 1'b0, 32'd0, 32'h80011234, 1);
        issue(3, 1'b0, 2'd1, 1'b1, 32'h1002, 32'd0, 1'b0, 5'd0, 32'h00008001, 3);
        push_beat(32'h1000, 4'b0010, 1'b0, 32'd0, 32'h000080FF, 2);
        issue(4, 1'b0, 2'd0, 1'b0, 32'h1001, 32'd0, 1'b0, 5'd0, 32'hFFFFFF80, 4);
        push_beat(32'h1000, 4'b0010, 1'b0, 32'd0, 32'h000080FF, 0);
        issue(5, 1'b0, 2'd0, 1'b1, 32'h1001, 32'd0, 1'b0, 5'd0, 32'h00000080, 2);
        push_beat(32'h1004, 4'b1111, 1'b0, 32'd0, 32'h01234567, 0);
        issue(6, 1'b0, 2'd3, 1'b0, 32'h1004, 32'd0, 1'b0, 5'd0, 32'h01234567, 2);
        push_beat(32'h1008, 4'b1111, 1'b1, 32'hCAFEF00D, 32'hFFFFFFFF, 0);
        issue(7, 1'b1, 2'd2, 1'b0, 32'h1008, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 2);
        push_beat(32'h1000, 4'b1000, 1'b1, 32'hAB000000, 32'hFFFFFFFF, 0);
        issue(8, 1'b1, 2'd0, 1'b0, 32'h1003, 32'h123456AB, 1'b0, 5'd0, 32'd0, 2);

`ifdef MEM_UNALIGNED_SPLIT_EN
        push_beat(32'h1000, 4'b1000, 1'b0, 32'd0, 32'hAABBCCDD, 0);
        push_beat(32'h1004, 4'b0111, 1'b0, 32'd0, 32'h11223344, 0);
        issue(10, 1'b0, 2'd2, 1'b0, 32'h1003, 32'd0, 1'b0, 5'd0, 32'h223344AA, 3);
        push_beat(32'h1000, 4'b1100, 1'b1, 32'h56780000, 32'd0, 0);
        push_beat(32'h1004, 4'b0011, 1'b1, 32'h00001234, 32'd0, 0);
        issue(11, 1'b1, 2'd2, 1'b0, 32'h1002, 32'h12345678, 1'b0, 5'd0, 32'd0, 3);
        push_beat(32'hFFFFFFFC, 4'b1110, 1'b0, 32'd0, 32'h44332211, 0);
        push_beat(32'h00000000, 4'b0001, 1'b0, 32'd0, 32'h88776655, 0);
        issue(12, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFD, 32'd0, 1'b0, 5'd0, 32'h55443322, 3);
        push_beat(32'h1000, 4'b0110, 1'b0, 32'd0, 32'h00ABCD00, 0);
        issue(13, 1'b0, 2'd1, 1'b0, 32'h1001, 32'd0, 1'b0, 5'd0, 32'hFFFFABCD, 2);
        push_beat(32'h1000, 4'b1000, 1'b0, 32'd0, 32'h7F000000, 0);
        push_beat(32'h1004, 4'b0001, 1'b0, 32'd0, 32'h000000EE, 1);
        issue(14, 1'b0, 2'd1, 1'b1, 32'h1003, 32'd0, 1'b0, 5'd0, 32'h0000EE7F, 4);
`else
        rc = req_cycles;
        issue(10, 1'b0, 2'd2, 1'b0, 32'h1001, 32'd0, 1'b1, 5'd4, 32'd0, 1);
        chk("fault_no_bus_req", 32'(req_cycles - rc), 32'd0);
        issue(11, 1'b1, 2'd1, 1'b0, 32'h1003, 32'h0000BEEF, 1'b1, 5'd5, 32'd0, 1);
        issue(12, 1'b0, 2'd1, 1'b1, 32'h1001, 32'd0, 1'b1, 5'd4, 32'd0, 1);
        issue(13, 1'b1, 2'd2, 1'b0, 32'h1002, 32'h12345678, 1'b1, 5'd5, 32'd0, 1);
        chk("fault_no_bus_req_all", 32'(req_cycles - rc), 32'd0);
`endif

        // No ack at all: bus error after TO request cycles
        rc = req_cycles;
        issue(15, 1'b0, 2'd2, 1'b0, 32'h3000, 32'd0, 1'b1, 5'd7, 32'd0, TO + 1);
        chk("timeout_req_cycles", 32'(req_cycles - rc), 32'(TO));

        // Reset in BEAT0, then a late ack while idle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h2000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_bus_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_bus_req_after", 32'(bus_req), 32'd0);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_bus_req", 32'(bus_req), 32'd0);
        chk("late_ack_ready", 32'(req_ready), 32'd1);

        push_beat(32'h1010, 4'b1111, 1'b0, 32'd0, 32'h0BADF00D, 0);
        issue(20, 1'b0, 2'd2, 1'b0, 32'h1010, 32'd0, 1'b0, 5'd0, 32'h0BADF00D, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
